// File: rtl/mdu_hilo_if.sv
// mdu_hilo_if: request/result bundle between the control unit and the
// multiply/divide unit.
//   start/op/a/b : op request from control (master -> slave)
//   busy/done    : stall indication and result-written pulse
//   hi/lo        : architectural HI/LO registers, fed to the writeback select
//   div0         : divide-by-zero flag, only when MDU_DIV0_FLAG_EN is defined
interface mdu_hilo_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
`ifdef MDU_DIV0_FLAG_EN
  logic             div0;

  modport master (output start, op, a, b, input busy, done, hi, lo, div0);
  modport slave  (input start, op, a, b, output busy, done, hi, lo, div0);
`else
  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
`endif
endinterface

// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit owning the HI/LO registers.
//   clk, rst_n : rising-edge clock, async active-low reset
//   bus.slave  : start/op/a/b in; busy/done/hi/lo (and div0) out
// Ops: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x NOP.
// MULT*/DIV* run IDLE -> CALC (WIDTH radix-2 steps) -> FIX (apply signs,
// write hi/lo, pulse done). Operands are reduced to magnitudes on the start
// edge so the core only ever does unsigned shift-add / shift-subtract.
// Optional feature macro: MDU_DIV0_FLAG_EN adds the sticky div0 flag output.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mdu_hilo_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH-1);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             is_div;
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder (sign of dividend)
  logic [WIDTH-1:0] opnd;      // |multiplicand| or |divisor|
  logic [WIDTH-1:0] acc_hi;    // partial product high / running remainder
  logic [WIDTH-1:0] acc_lo;    // multiplier bits / dividend bits -> quotient
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  logic             accept, arith;
  logic             sa, sb;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift, div_sub;
  logic             div_ge;
  logic [2*WIDTH-1:0] prod;

  // start is only honoured in IDLE; while busy every op is dropped.
  assign accept = bus.start && (state == IDLE);
  assign arith  = accept && !bus.op[2];

  // op[0]=1 selects the unsigned variants.
  assign sa    = !bus.op[0] && bus.a[WIDTH-1];
  assign sb    = !bus.op[0] && bus.b[WIDTH-1];
  assign mag_a = sa ? -bus.a : bus.a;
  assign mag_b = sb ? -bus.b : bus.b;

  // Multiply step: conditionally add, then shift {acc_hi,acc_lo} right.
  assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
  // Restoring divide step: shift in the next dividend bit, trial-subtract.
  assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
  assign div_ge    = div_shift >= {1'b0, opnd};
  assign div_sub   = div_shift - {1'b0, opnd};
  assign prod      = neg_q ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arith) state_nxt = CALC;
      CALC:    if (cnt == CNT_LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      opnd   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (arith) begin
            cnt    <= '0;
            is_div <= bus.op[1];
            neg_q  <= sa ^ sb;
            neg_r  <= sa;
            opnd   <= mag_b;
            acc_hi <= '0;
            acc_lo <= mag_a;
          end else if (accept && bus.op == 3'b100) begin
            hi_q <= bus.a;
          end else if (accept && bus.op == 3'b101) begin
            lo_q <= bus.a;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          if (is_div) begin
            acc_hi <= div_ge ? div_sub[WIDTH-1:0] : div_shift[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], div_ge};
          end else begin
            acc_hi <= mul_sum[WIDTH:1];
            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
          end
        end
        FIX: begin
          // Divide by zero needs no special case: every trial subtract
          // succeeds, giving an all-ones quotient and remainder = |a|.
          if (is_div) begin
            lo_q <= neg_q ? -acc_lo : acc_lo;
            hi_q <= neg_r ? -acc_hi : acc_hi;
          end else begin
            hi_q <= prod[2*WIDTH-1:WIDTH];
            lo_q <= prod[WIDTH-1:0];
          end
          done_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef MDU_DIV0_FLAG_EN
  logic b_zero, div0_q;

  // Sticky until the next accepted non-NOP start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_zero <= 1'b0;
      div0_q <= 1'b0;
    end else begin
      if (arith) b_zero <= (bus.b == '0);
      if (accept && !(bus.op[2] && bus.op[1]))
        div0_q <= 1'b0;
      else if (state == FIX && is_div && b_zero)
        div0_q <= 1'b1;
    end
  end

  assign bus.div0 = div0_q;
`endif

  assign bus.busy = (state != IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_hilo.sv
module tb_mdu_hilo;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic chk_en = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  mdu_hilo_if #(.WIDTH(32)) bus ();
  mdu_hilo #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference results straight from the arithmetic definition of each op.
  function automatic logic [63:0] model_res(input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b);
    longint          sp, sa, sb, q, r;
    longint unsigned up, ua, ub;
    logic [63:0]     v;
    logic [31:0]     rh, rl;
    ua = {32'b0, a};
    ub = {32'b0, b};
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    rh = 32'h0;
    rl = 32'h0;
    case (op)
      3'b000: begin sp = sa * sb; v = sp; rh = v[63:32]; rl = v[31:0]; end
      3'b001: begin up = ua * ub; v = up; rh = v[63:32]; rl = v[31:0]; end
      3'b010: begin
        if (b == 0) begin rh = a; rl = (sa >= 0) ? 32'hFFFF_FFFF : 32'h1; end
        else begin
          q = sa / sb; r = sa % sb;
          v = q; rl = v[31:0];
          v = r; rh = v[31:0];
        end
      end
      3'b011: begin
        if (b == 0) begin rh = a; rl = 32'hFFFF_FFFF; end
        else begin
          v = ua / ub; rl = v[31:0];
          v = ua % ub; rh = v[31:0];
        end
      end
      default: ;
    endcase
    return {rh, rl};
  endfunction

  // Behavioural model: a countdown to result, nothing about internal steps.
  int          m_cnt;
  logic        m_done;
  logic [31:0] m_hi, m_lo;
  logic [63:0] m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt <= 0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0; m_pend <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_cnt == 0) begin
        if (bus.start) begin
          if (!bus.op[2]) begin
            m_pend <= model_res(bus.op, bus.a, bus.b);
            m_cnt  <= 33;
          end else if (bus.op == 3'b100) m_hi <= bus.a;
          else if (bus.op == 3'b101) m_lo <= bus.a;
        end
      end else begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("cyc_busy", {31'b0, bus.busy}, {31'b0, m_cnt != 0});
      chk("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
      chk("cyc_hi", bus.hi, m_hi);
      chk("cyc_lo", bus.lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Drive a start for one edge, then scramble a/b to show they are not used.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    step();
    bus.start = 1'b0; bus.op = 3'b110; bus.a = $urandom; bus.b = $urandom;
  endtask

  // Called right after the start edge; n counts edges including the start edge.
  task automatic wait_done(output int n, output int nbusy);
    n = 1; nbusy = 0;
    while (!bus.done && n < 40) begin
      nbusy += int'(bus.busy);
      step();
      n++;
    end
    if (!bus.done) begin
      n_chk++; n_fail++;
      $display("FAIL done_timeout: got no done expected done within 40 edges");
    end
  endtask

  task automatic run(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] ehi, input logic [31:0] elo, input string name);
    int n, nb;
    issue(op, a, b);
    wait_done(n, nb);
    chk({name, "_hi"}, bus.hi, ehi);
    chk({name, "_lo"}, bus.lo, elo);
    step();
  endtask

  initial begin
    int n, nb;
    bus.start = 1'b0; bus.op = 3'b110; bus.a = '0; bus.b = '0;
    repeat (3) step();
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("rst_done", {31'b0, bus.done}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    step();

    // 1: latency and busy window
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, nb);
    chk("t1_latency", n, 34);
    chk("t1_busy_cycles", nb, 33);
    chk("t1_hi", bus.hi, 32'hFFFF_FFFE);
    chk("t1_lo", bus.lo, 32'h0000_0001);
    step();
    chk("t1_done_1cyc", {31'b0, bus.done}, 32'h0);

    // 2: signed ops
    run(3'b000, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF, 32'hFFFF_FFF1, "t2_mult");
    run(3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "t2_div");
    run(3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "t2_div_negb");
    run(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "t2_div_ovf");
    run(3'b000, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "t2_mult_min");

    // 3: divide by zero
    run(3'b011, 32'h0000_0007, 32'h0, 32'h0000_0007, 32'hFFFF_FFFF, "t3_divu0");
`ifdef MDU_DIV0_FLAG_EN
    chk("t3_div0_set", {31'b0, bus.div0}, 32'h1);
`endif
    run(3'b010, 32'hFFFF_FFF9, 32'h0, 32'hFFFF_FFF9, 32'h0000_0001, "t3_div0_neg");
    run(3'b010, 32'h0000_0009, 32'h0, 32'h0000_0009, 32'hFFFF_FFFF, "t3_div0_pos");
`ifdef MDU_DIV0_FLAG_EN
    issue(3'b001, 32'h2, 32'h3);
    chk("t3_div0_clr", {31'b0, bus.div0}, 32'h0);
    wait_done(n, nb);
    step();
`endif

    // 4: MTHI/MTLO back to back, plus a NOP
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 32'h1234_5678;
    step();
    chk("t4_hi", bus.hi, 32'h1234_5678);
    chk("t4_busy", {31'b0, bus.busy}, 32'h0);
    bus.op = 3'b101; bus.a = 32'h9ABC_DEF0;
    step();
    chk("t4_lo", bus.lo, 32'h9ABC_DEF0);
    chk("t4_done", {31'b0, bus.done}, 32'h0);
    bus.op = 3'b111; bus.a = 32'h5555_5555;
    step();
    chk("t4_nop_hi", bus.hi, 32'h1234_5678);
    bus.start = 1'b0;
    step();

    // 5: MTLO while busy is dropped
    issue(3'b001, 32'h3, 32'h4);
    repeat (8) step();
    bus.start = 1'b1; bus.op = 3'b101; bus.a = 32'hDEAD_BEEF;
    step();
    bus.start = 1'b0;
    chk("t5_hold_lo", bus.lo, 32'h9ABC_DEF0);
    wait_done(n, nb);
    chk("t5_hi", bus.hi, 32'h0);
    chk("t5_lo", bus.lo, 32'h0000_000C);
    step();

    // 6: async reset mid-op, then re-run
    issue(3'b011, 32'd100, 32'd7);
    repeat (14) step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hi", bus.hi, 32'h0);
    chk("t6_rst_lo", bus.lo, 32'h0);
    chk("t6_rst_busy", {31'b0, bus.busy}, 32'h0);
    chk("t6_rst_done", {31'b0, bus.done}, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    run(3'b011, 32'd100, 32'd7, 32'h0000_0002, 32'h0000_000E, "t6_rerun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
